// File: rtl/rs_alloc_multi_pkg.sv
// Shared definitions for the reservation-station allocator:
// default sizes, counter types, pick direction and a popcount helper.
package rs_alloc_pkg;

    localparam int RS_WIDTH_DEF = 32;
    localparam int RS_PORTS_DEF = 4;
    // Widest entry vector the popcount helper accepts.
    localparam int RS_MAX_W     = 64;

    typedef logic [$clog2(RS_WIDTH_DEF+1)-1:0] cnt_t;
    typedef logic [$clog2(RS_MAX_W+1)-1:0]     pc_t;

    // Which end of the free vector a channel allocates from.
    typedef enum logic {
        PICK_LOW  = 1'b0,
        PICK_HIGH = 1'b1
    } pick_dir_e;

    function automatic pc_t popcount(input logic [RS_MAX_W-1:0] v);
        pc_t c;
        c = '0;
        for (int i = 0; i < RS_MAX_W; i++) begin
            c = c + pc_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rs_alloc_multi_if.sv
// Rename <-> allocator bus: requests, releases and per-channel grants.
// master = rename/dispatch side, slave = allocator.
interface rs_alloc_multi_if #(
    parameter int WIDTH = 32,
    parameter int PORTS = 4
);
    localparam int CNT_W = $clog2(WIDTH+1);

    logic [PORTS-1:0]       alloc_req;
    logic                   stall;
    logic                   flush;
    logic [WIDTH-1:0]       free_mask;
    logic [PORTS*WIDTH-1:0] new_sel;
    logic [PORTS-1:0]       new_vld;
    logic                   do_stall;
    logic [CNT_W-1:0]       free_cnt;
    logic                   stall_early;

    modport master (
        output alloc_req, stall, flush, free_mask,
        input  new_sel, new_vld, do_stall, free_cnt, stall_early
    );

    modport slave (
        input  alloc_req, stall, flush, free_mask,
        output new_sel, new_vld, do_stall, free_cnt, stall_early
    );
endinterface

// File: rtl/rs_alloc_multi_pick.sv
// Returns the K-th set bit (0-based) of a free vector, one-hot, counted
// from the low or high end. All zero when fewer than K+1 bits are set.
module rs_alloc_pick
    import rs_alloc_pkg::*;
#(
    parameter int        WIDTH = 32,
    parameter pick_dir_e DIR   = PICK_LOW,
    parameter int        K     = 0
) (
    input  logic [WIDTH-1:0] free,
    output logic [WIDTH-1:0] sel
);

    // Scan from the chosen end, marking the bit where the running count hits K.
    always_comb begin
        int seen;
        int idx;
        // NOTE: blocking '=' here because seen/idx are scratch values that must
        // update within one evaluation; registers elsewhere use '<='.
        sel  = '0;
        seen = 0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = (DIR == PICK_HIGH) ? (WIDTH - 1 - i) : i;
            if (free[idx]) begin
                if (seen == K) sel[idx] = 1'b1;
                seen = seen + 1;
            end
        end
    end

endmodule

// File: rtl/rs_alloc_multi.sv
// Reservation-station entry allocator: grants up to PORTS free entries per
// cycle, all-or-nothing, from alternating ends of the free bitmap.
// Optional feature macro: RS_ALLOC_WATERMARK_EN (registered early stall).
module rs_alloc_multi
    import rs_alloc_pkg::*;
#(
    parameter int WIDTH    = RS_WIDTH_DEF,
    parameter int PORTS    = RS_PORTS_DEF,
    parameter int HEADROOM = 2
) (
    input  logic               clk,
    input  logic               rst,
    rs_alloc_multi_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH+1);

    if (PORTS < 1 || PORTS > 8 || WIDTH < 2*PORTS || WIDTH > RS_MAX_W || HEADROOM < 0)
    begin : g_bad_cfg
        $error("rs_alloc_multi: unsupported WIDTH/PORTS/HEADROOM");
    end

    logic [WIDTH-1:0]       busy;
    logic [WIDTH-1:0]       busy_next;
    logic [WIDTH-1:0]       free_vec;
    logic [WIDTH-1:0]       grant_vec;
    logic [PORTS*WIDTH-1:0] pick;
    logic [CNT_W-1:0]       free_cnt_q;
    logic [CNT_W-1:0]       free_cnt_next;
    pc_t                    need;
    logic                   collide;
    logic                   stall_int;
    logic                   commit;

    assign free_vec = ~busy;

    // Channel g: even channels count from the low end, odd from the high end,
    // each taking the (g/2)-th free entry from its side.
    for (genvar g = 0; g < PORTS; g++) begin : g_pick
        rs_alloc_pick #(
            .WIDTH (WIDTH),
            .DIR   ((g % 2) ? PICK_HIGH : PICK_LOW),
            .K     (g / 2)
        ) u_pick (
            .free (free_vec),
            .sel  (pick[g*WIDTH +: WIDTH])
        );
    end

    // A requested channel with no pick, or two requested channels sharing a
    // pick, means the group cannot be granted whole.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (bus.alloc_req[i] && (pick[i*WIDTH +: WIDTH] == '0)) collide = 1'b1;
            for (int j = i + 1; j < PORTS; j++) begin
                if (bus.alloc_req[i] && bus.alloc_req[j] &&
                    |(pick[i*WIDTH +: WIDTH] & pick[j*WIDTH +: WIDTH])) collide = 1'b1;
            end
        end
    end

    assign need      = popcount(RS_MAX_W'(bus.alloc_req));
    assign stall_int = bus.flush | (need > pc_t'(free_cnt_q)) | collide;
    assign commit    = ~stall_int & ~bus.stall & ~rst;

    // Per-channel outputs and the set of entries committed this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        bus.new_sel = '0;
        bus.new_vld = '0;
        grant_vec   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (bus.alloc_req[i] && !stall_int && !rst)
                bus.new_sel[i*WIDTH +: WIDTH] = pick[i*WIDTH +: WIDTH];
            if (bus.alloc_req[i] && commit) begin
                bus.new_vld[i] = 1'b1;
                grant_vec      = grant_vec | pick[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.do_stall = stall_int & ~rst;

    // Frees take effect next cycle only; flush wins over frees and grants.
    always_comb begin
        if (bus.flush) busy_next = '0;
        else           busy_next = (busy & ~bus.free_mask) | grant_vec;
    end

    assign free_cnt_next = CNT_W'(WIDTH) - CNT_W'(popcount(RS_MAX_W'(busy_next)));

    // Busy bitmap and its free count, kept in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            free_cnt_q <= CNT_W'(WIDTH);
        end else begin
            busy       <= busy_next;
            free_cnt_q <= free_cnt_next;
        end
    end

    assign bus.free_cnt = free_cnt_q;

    // Releasing an entry that is not busy points at a bookkeeping bug upstream.
    always @(posedge clk) begin
        if (!rst && !bus.flush) assert ((bus.free_mask & ~busy) == '0);
    end

`ifdef RS_ALLOC_WATERMARK_EN
    logic stall_early_q;

    // Almost-full flag computed from the next free count, one cycle ahead.
    always_ff @(posedge clk) begin
        if (rst) stall_early_q <= 1'b0;
        else     stall_early_q <= (int'(free_cnt_next) < PORTS + HEADROOM);
    end

    assign bus.stall_early = stall_early_q;
`else
    assign bus.stall_early = 1'b0;
`endif

endmodule
